mem_arbiter: RTL and testbench

//  Shares one memory port between the fetch stage (ifu, read-only) and the memory stage (mmu, read/write).

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch stage (read-only) and the mmu (read/write).
// One transaction is in flight at a time; simultaneous requests alternate round-robin.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req_valid,
    output logic                      if_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] if_req_addr,
    output logic                      if_resp_valid,
    input  logic                      if_resp_ready,
    output logic [DATA_WIDTH-1:0]     if_resp_data,
    input  logic                      mem_req_valid_i,
    output logic                      mem_req_ready_o,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_i,
    input  logic                      mem_req_wen_i,
    input  logic [DATA_WIDTH-1:0]     mem_req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   mem_req_wmask_i,
    output logic                      mem_resp_valid_o,
    input  logic                      mem_resp_ready_i,
    output logic [DATA_WIDTH-1:0]     mem_resp_data_o,
    output logic                      bus_req_valid,
    input  logic                      bus_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0] bus_req_addr,
    output logic                      bus_req_wen,
    output logic [DATA_WIDTH-1:0]     bus_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   bus_req_wmask,
    input  logic                      bus_resp_valid,
    output logic                      bus_resp_ready,
    input  logic [DATA_WIDTH-1:0]     bus_resp_data,
    output logic [1:0]                owner
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_MEM  = 2'b10;

    logic [1:0]                state_q, state_d;
    logic [1:0]                owner_q;
    logic                      last_mem_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic                      wen_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wmask_q;
    logic [DATA_WIDTH-1:0]     data_q;

    logic idle;
    logic grant_if;
    logic grant_mem;
    logic resp_done;

    // Grants are suppressed while reset is held so no ready leaks out during reset.
    assign idle      = (state_q == ST_IDLE) && !rst;
    assign grant_if  = idle && if_req_valid && (!mem_req_valid_i || last_mem_q);
    assign grant_mem = idle && mem_req_valid_i && (!if_req_valid || !last_mem_q);
    assign resp_done = (state_q == ST_RESP) &&
                       (((owner_q == OWN_IF) && if_resp_ready) ||
                        ((owner_q == OWN_MEM) && mem_resp_ready_i));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_if || grant_mem) state_d = ST_ISSUE;
            ST_ISSUE: if (bus_req_ready) state_d = ST_WAIT;
            ST_WAIT:  if (bus_resp_valid) state_d = ST_RESP;
            ST_RESP:  if (resp_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            last_mem_q <= 1'b1;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_if) begin
                owner_q    <= OWN_IF;
                last_mem_q <= 1'b0;
                addr_q     <= if_req_addr;
                wen_q      <= 1'b0;
                wdata_q    <= '0;
                wmask_q    <= '0;
            end else if (grant_mem) begin
                owner_q    <= OWN_MEM;
                last_mem_q <= 1'b1;
                addr_q     <= mem_req_addr_i;
                wen_q      <= mem_req_wen_i;
                wdata_q    <= mem_req_wdata_i;
                wmask_q    <= mem_req_wmask_i;
            end else if (resp_done) begin
                owner_q <= OWN_NONE;
            end
            if ((state_q == ST_WAIT) && bus_resp_valid) begin
                data_q <= bus_resp_data;
            end
        end
    end

    assign if_req_ready     = grant_if;
    assign mem_req_ready_o  = grant_mem;
    assign bus_req_valid    = (state_q == ST_ISSUE);
    assign bus_req_addr     = addr_q;
    assign bus_req_wen      = wen_q;
    assign bus_req_wdata    = wdata_q;
    assign bus_req_wmask    = wmask_q;
    assign bus_resp_ready   = (state_q == ST_WAIT);
    assign if_resp_valid    = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign mem_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_MEM);
    assign if_resp_data     = data_q;
    assign mem_resp_data_o  = data_q;
    assign owner            = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: master drivers push expected responses, a monitor pops them.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic [31:0] if_req_addr, if_resp_data;
    logic        mem_req_valid_i, mem_req_ready_o, mem_req_wen_i, mem_resp_valid_o;
    logic        mem_resp_ready_i;
    logic [31:0] mem_req_addr_i, mem_req_wdata_i, mem_resp_data_o;
    logic [3:0]  mem_req_wmask_i;
    logic        bus_req_valid, bus_req_ready, bus_req_wen, bus_resp_valid, bus_resp_ready;
    logic [31:0] bus_req_addr, bus_req_wdata, bus_resp_data;
    logic [3:0]  bus_req_wmask;
    logic [1:0]  owner;

    mem_arbiter #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_resp_data(if_resp_data),
        .mem_req_valid_i(mem_req_valid_i), .mem_req_ready_o(mem_req_ready_o),
        .mem_req_addr_i(mem_req_addr_i), .mem_req_wen_i(mem_req_wen_i),
        .mem_req_wdata_i(mem_req_wdata_i), .mem_req_wmask_i(mem_req_wmask_i),
        .mem_resp_valid_o(mem_resp_valid_o), .mem_resp_ready_i(mem_resp_ready_i),
        .mem_resp_data_o(mem_resp_data_o),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
        .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
        .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
        .bus_resp_data(bus_resp_data), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int n_chk = 0;
    int n_if_resp = 0, n_mem_resp = 0;
    int t_acc_if, t_acc_mem, t_issue, t_busresp, t_resp_if, t_resp_mem;
    bit stress = 0;
    bit spur = 0;
    int mem_hold = 0;
    int rq_lim = 0, rs_lim = 0;

    logic [31:0] if_q[$];
    mreq_t       mem_q[$];
    logic [31:0] sb_if[$], sb_mem[$];
    int          grant_log[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bus_mem [logic [29:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : (a ^ 32'h5A5A0000);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a[31:2]) ? bus_mem[a[31:2]] : (a ^ 32'h5A5A0000);
    endfunction

    // Fetch master: holds valid until accepted, then presents the next queued address.
    initial begin
        bit hs = 0;
        if_req_valid = 0;
        if_req_addr  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if_req_valid = 0;
                hs = 0;
            end else begin
                if (hs) begin
                    if_req_valid = 0;
                    hs = 0;
                end
                if (!if_req_valid && if_q.size() > 0 && !(stress && $urandom_range(0, 3) == 0))
                begin
                    if_req_addr  = if_q.pop_front();
                    if_req_valid = 1;
                end
                #1;
                if (if_req_valid && if_req_ready) begin
                    hs = 1;
                    sb_if.push_back(ref_rd(if_req_addr));
                    grant_log.push_back(1);
                    t_acc_if = cyc;
                end
            end
        end
    end

    // MMU master; the reference memory is updated in acceptance order.
    initial begin
        bit hs = 0;
        mreq_t r;
        logic [31:0] w;
        mem_req_valid_i = 0;
        mem_req_addr_i  = 0;
        mem_req_wen_i   = 0;
        mem_req_wdata_i = 0;
        mem_req_wmask_i = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_req_valid_i = 0;
                hs = 0;
            end else begin
                if (hs) begin
                    mem_req_valid_i = 0;
                    hs = 0;
                end
                if (!mem_req_valid_i && mem_q.size() > 0 &&
                    !(stress && $urandom_range(0, 3) == 0)) begin
                    r = mem_q.pop_front();
                    mem_req_addr_i  = r.addr;
                    mem_req_wen_i   = r.wen;
                    mem_req_wdata_i = r.wdata;
                    mem_req_wmask_i = r.wmask;
                    mem_req_valid_i = 1;
                end
                #1;
                if (mem_req_valid_i && mem_req_ready_o) begin
                    hs = 1;
                    w = ref_rd(mem_req_addr_i);
                    if (mem_req_wen_i) begin
                        w = merge(w, mem_req_wdata_i, mem_req_wmask_i);
                        ref_mem[mem_req_addr_i[31:2]] = w;
                    end
                    sb_mem.push_back(w);
                    grant_log.push_back(2);
                    t_acc_mem = cyc;
                end
            end
        end
    end

    // Memory responder: programmable accept and response latency; writes return the merged word.
    initial begin
        int ph = 0, cnt = 0;
        logic [31:0] ca, cd, w, rsp_word;
        logic cw;
        logic [3:0] cm;
        bus_req_ready  = 0;
        bus_resp_valid = 0;
        bus_resp_data  = 0;
        forever begin
            @(negedge clk);
            bus_req_ready  = 0;
            bus_resp_valid = 0;
            if (rst) begin
                ph = 0;
                cnt = 0;
            end else if (ph == 0 && bus_req_valid) begin
                if (cnt == 0) begin
                    ca = bus_req_addr; cw = bus_req_wen; cd = bus_req_wdata; cm = bus_req_wmask;
                    t_issue = cyc;
                    if (stress) begin
                        rq_lim = $urandom_range(0, 2);
                        rs_lim = $urandom_range(0, 2);
                    end
                    if (owner == 2'b01) chk("fetch_is_read", {27'd0, bus_req_wen, bus_req_wmask}, 0);
                end else begin
                    chk("issue_stable_addr", bus_req_addr, ca);
                    chk("issue_stable_ctl", {27'd0, bus_req_wen, bus_req_wmask}, {27'd0, cw, cm});
                    chk("issue_stable_wdata", bus_req_wdata, cd);
                end
                if (cnt < rq_lim) begin
                    cnt++;
                    if (spur) begin
                        bus_resp_valid = 1;
                        bus_resp_data  = 32'hBAD0BAD0;
                        spur = 0;
                    end
                end else begin
                    bus_req_ready = 1;
                    w = bus_rd(bus_req_addr);
                    if (bus_req_wen) begin
                        w = merge(w, bus_req_wdata, bus_req_wmask);
                        bus_mem[bus_req_addr[31:2]] = w;
                    end
                    rsp_word = w;
                    ph = 1;
                    cnt = 0;
                end
            end else if (ph == 1) begin
                if (cnt < rs_lim) cnt++;
                else begin
                    bus_resp_valid = 1;
                    bus_resp_data  = rsp_word;
                    t_busresp = cyc;
                    ph = 0;
                    cnt = 0;
                end
            end
        end
    end

    // Response-side ready driver.
    initial begin
        if_resp_ready    = 0;
        mem_resp_ready_i = 0;
        forever begin
            @(negedge clk);
            if_resp_ready = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mem_hold > 0 && mem_resp_valid_o) begin
                mem_resp_ready_i = 0;
                mem_hold--;
            end else begin
                mem_resp_ready_i = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each response handshake and checks output invariants.
    initial begin
        logic prev_if = 0, prev_mem = 0;
        int if_skip = 0, mem_skip = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_if = 0; prev_mem = 0; if_skip = 0; mem_skip = 0;
                continue;
            end
            if (bus_req_valid || bus_resp_ready) chk("owner_busy", {31'd0, owner == 2'b00}, 0);
            if (if_resp_valid || mem_resp_valid_o) begin
                chk("one_resp", {31'd0, if_resp_valid && mem_resp_valid_o}, 0);
                chk("no_grant_in_resp", {30'd0, if_req_ready, mem_req_ready_o}, 0);
            end
            if (if_resp_valid) begin
                chk("owner_if", {30'd0, owner}, 1);
                if (!prev_if) t_resp_if = cyc;
                if (sb_if.size() == 0) chk("if_resp_unexpected", 1, 0);
                else if (if_resp_ready) begin
                    chk("if_resp_data", if_resp_data, sb_if.pop_front());
                    n_if_resp++;
                end else chk("if_resp_hold", if_resp_data, sb_if[0]);
            end
            if (mem_resp_valid_o) begin
                chk("owner_mem", {30'd0, owner}, 2);
                if (!prev_mem) t_resp_mem = cyc;
                if (sb_mem.size() == 0) chk("mem_resp_unexpected", 1, 0);
                else if (mem_resp_ready_i) begin
                    chk("mem_resp_data", mem_resp_data_o, sb_mem.pop_front());
                    n_mem_resp++;
                end else chk("mem_resp_hold", mem_resp_data_o, sb_mem[0]);
            end
            // A waiting master may be passed over at most once.
            if (mem_req_valid_i && mem_req_ready_o) begin
                if (if_req_valid) begin
                    if_skip++;
                    chk("if_starve", {31'd0, if_skip > 1}, 0);
                end
                mem_skip = 0;
            end
            if (if_req_valid && if_req_ready) begin
                if (mem_req_valid_i) begin
                    mem_skip++;
                    chk("mem_starve", {31'd0, mem_skip > 1}, 0);
                end
                if_skip = 0;
            end
            prev_if = if_resp_valid;
            prev_mem = mem_resp_valid_o;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        if_q.delete(); mem_q.delete(); sb_if.delete(); sb_mem.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        @(posedge clk);
    endtask

    task automatic wait_done(input int ni, input int nm, input int budget, input string name);
        int k = 0;
        while ((n_if_resp < ni || n_mem_resp < nm) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_if_resp < ni || n_mem_resp < nm) begin
            errors++;
            n_chk++;
            $display("FAIL %s_timeout: got if=%0d mem=%0d responses, expected if=%0d mem=%0d",
                     name, n_if_resp, n_mem_resp, ni, nm);
        end
        @(posedge clk);
    endtask

    task automatic push_mem(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] m);
        mreq_t r;
        r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
        mem_q.push_back(r);
    endtask

    initial begin
        int k;
        rst = 1;
        @(negedge clk);
        #1;
        chk("rst_ctrl", {26'd0, if_req_ready, if_resp_valid, mem_req_ready_o, mem_resp_valid_o,
                         bus_req_valid, bus_resp_ready}, 0);
        chk("rst_owner", {30'd0, owner}, 0);
        chk("rst_fields", bus_req_addr | bus_req_wdata | {27'd0, bus_req_wen, bus_req_wmask}, 0);
        chk("rst_data", if_resp_data | mem_resp_data_o, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);

        // Fetch-only read, zero-wait memory.
        ref_mem[30'h20000000] = 32'h00000413;
        bus_mem[30'h20000000] = 32'h00000413;
        if_q.push_back(32'h80000000);
        wait_done(1, 0, 50, "t1");
        chk("t1_issue_lat", t_issue - t_acc_if, 1);
        chk("t1_resp_lat", t_resp_if - t_acc_if, 3);

        // Simultaneous requests after reset: fetch first, then alternate.
        do_reset();
        grant_log.delete();
        if_q.push_back(32'h80000000); if_q.push_back(32'h80000010);
        push_mem(32'h80000020, 0, 0, 0); push_mem(32'h80000030, 0, 0, 0);
        wait_done(n_if_resp + 2, n_mem_resp + 2, 100, "t2");
        chk("t2_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("t2_grant_order", grant_log[i], (i % 2 == 0) ? 1 : 2);

        // MMU write with a slow accept; then read it back through fetch.
        rq_lim = 3;
        push_mem(32'h80001000, 1, 32'hDEADBEEF, 4'hF);
        wait_done(n_if_resp, n_mem_resp + 1, 100, "t3");
        chk("t3_resp_after_bus", t_resp_mem - t_busresp, 1);
        rq_lim = 0;
        if_q.push_back(32'h80001000);
        wait_done(n_if_resp + 1, n_mem_resp, 50, "t3_rd");

        // Spurious bus response during ISSUE, then a stalled mmu response with fetch waiting.
        rq_lim = 2;
        spur = 1;
        mem_hold = 5;
        push_mem(32'h80001000, 0, 0, 0);
        k = 0;
        while (!mem_resp_valid_o && k < 50) begin @(negedge clk); k++; end
        if_q.push_back(32'h80000000);
        wait_done(n_if_resp + 1, n_mem_resp + 1, 100, "t4");
        chk("t4_fetch_after_mmu", {31'd0, t_acc_if > t_resp_mem + 5}, 1);
        rq_lim = 0;

        // Reset while waiting for memory.
        rs_lim = 20;
        push_mem(32'h80000000, 0, 0, 0);
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!bus_resp_ready && k < 50);
        chk("t5_reached_wait", {31'd0, bus_resp_ready}, 1);
        #1;
        rst = 1;
        #1;
        chk("t5_rst_ctrl", {26'd0, if_req_ready, if_resp_valid, mem_req_ready_o, mem_resp_valid_o,
                            bus_req_valid, bus_resp_ready}, 0);
        chk("t5_rst_owner", {30'd0, owner}, 0);
        sb_mem.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        rs_lim = 0;
        @(posedge clk);
        grant_log.delete();
        if_q.push_back(32'h80000040);
        push_mem(32'h80000044, 0, 0, 0);
        wait_done(n_if_resp + 1, n_mem_resp + 1, 100, "t5");
        chk("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : 0, 1);

        // Random stress over a small address window so reads observe earlier writes.
        stress = 1;
        for (int i = 0; i < 1500; i++) begin
            if_q.push_back(32'h80002000 + {27'd0, 3'($urandom_range(0, 7)), 2'b00});
            push_mem(32'h80002000 + {27'd0, 3'($urandom_range(0, 7)), 2'b00},
                     1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        wait_done(n_if_resp + 1500, n_mem_resp + 1500, 60000, "t6");
        chk("t6_sb_empty", sb_if.size() + sb_mem.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, n_chk);
        $finish;
    end

endmodule
